clk_ena_gen: RTL and testbench

CLK_ENA_GEN -- requirements
Module: clk_ena_gen

---
 rtl/clk_ena_gen_if.sv | 42 ++++
 rtl/clk_ena_gen.sv | 90 +++++++++
 tb/tb_clk_ena_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_ena_gen_if.sv
// clk_ena_gen_if
// Groups the control inputs and the phase/enable outputs of clk_ena_gen.
// Widths are derived from the same three parameters the generator uses, so
// both sides must be instantiated with matching SAM_DIV / SPS / FRAME_LEN.
//   run, sync          : count enable and synchronous realignment request
//   clk_phase          : sys_clk index within the current sample
//   sam_phase          : sample index within the current symbol
//   sym_count          : symbol index within the current frame
//   sam_clk_ena        : one-cycle sample enable
//   sym_clk_ena        : one-cycle symbol enable
//   frame_ena          : one-cycle frame-boundary enable
// master drives run/sync, slave (the generator) drives everything else.
interface clk_ena_gen_if #(
  parameter int SAM_DIV   = 4,
  parameter int SPS       = 4,
  parameter int FRAME_LEN = 64
);
  localparam int DIV_W = (SAM_DIV   > 1) ? $clog2(SAM_DIV)   : 1;
  localparam int SPS_W = (SPS       > 1) ? $clog2(SPS)       : 1;
  localparam int FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic             run;
  logic             sync;
  logic [DIV_W-1:0] clk_phase;
  logic [SPS_W-1:0] sam_phase;
  logic [FRM_W-1:0] sym_count;
  logic             sam_clk_ena;
  logic             sym_clk_ena;
  logic             frame_ena;

  modport master (
    output run, sync,
    input  clk_phase, sam_phase, sym_count,
    input  sam_clk_ena, sym_clk_ena, frame_ena
  );

  modport slave (
    input  run, sync,
    output clk_phase, sam_phase, sym_count,
    output sam_clk_ena, sym_clk_ena, frame_ena
  );
endinterface

// File: rtl/clk_ena_gen.sv
// clk_ena_gen
// Cascaded divider producing sample, symbol and frame enables from sys_clk.
// Three counters (sys_clk-in-sample, sample-in-symbol, symbol-in-frame) are
// registered; the enables are decoded combinationally from those registers
// and the current run/sync inputs, so they appear in the same cycle as the
// terminal count with no extra latency.
// Ports:
//   sys_clk : sole clock, rising edge
//   reset   : synchronous, active-high; clears counters, masks enables
//   bus     : clk_ena_gen_if.slave (run, sync in; phases and enables out)
module clk_ena_gen #(
  parameter int SAM_DIV   = 4,
  parameter int SPS       = 4,
  parameter int FRAME_LEN = 64
) (
  input logic          sys_clk,
  input logic          reset,
  clk_ena_gen_if.slave bus
);
  localparam int DIV_W = (SAM_DIV   > 1) ? $clog2(SAM_DIV)   : 1;
  localparam int SPS_W = (SPS       > 1) ? $clog2(SPS)       : 1;
  localparam int FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // Terminal values and increment constants sized to each counter.
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAM_DIV - 1);
  localparam logic [SPS_W-1:0] SPS_LAST = SPS_W'(SPS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [SPS_W-1:0] SPS_ONE  = SPS_W'(1);
  localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);

  logic [DIV_W-1:0] clkPhase_q, clkPhase_d;
  logic [SPS_W-1:0] samPhase_q, samPhase_d;
  logic [FRM_W-1:0] symCount_q, symCount_d;
  logic             advance;
  logic             samEna;
  logic             symEna;
  logic             frameEna;

  // Enable decode. Reset and sync both suppress counting, so the enables are
  // masked by them here rather than by a separate output stage.
  always_comb begin
    advance  = bus.run & ~bus.sync & ~reset;
    samEna   = advance & (clkPhase_q == DIV_LAST);
    symEna   = samEna  & (samPhase_q == SPS_LAST);
    frameEna = symEna  & (symCount_q == FRM_LAST);
  end

  // Next-state: sync zeroes everything; otherwise each level advances only
  // when the level below reaches its terminal count. Wrapping on equality
  // with the last value keeps non-power-of-two moduli in range.
  always_comb begin
    clkPhase_d = clkPhase_q;
    samPhase_d = samPhase_q;
    symCount_d = symCount_q;
    if (bus.sync) begin
      clkPhase_d = '0;
      samPhase_d = '0;
      symCount_d = '0;
    end else if (bus.run) begin
      clkPhase_d = (clkPhase_q == DIV_LAST) ? '0 : clkPhase_q + DIV_ONE;
      if (samEna) begin
        samPhase_d = (samPhase_q == SPS_LAST) ? '0 : samPhase_q + SPS_ONE;
      end
      if (symEna) begin
        symCount_d = (symCount_q == FRM_LAST) ? '0 : symCount_q + FRM_ONE;
      end
    end
  end

  // Counter registers with synchronous reset taking priority over all else.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      clkPhase_q <= '0;
      samPhase_q <= '0;
      symCount_q <= '0;
    end else begin
      clkPhase_q <= clkPhase_d;
      samPhase_q <= samPhase_d;
      symCount_q <= symCount_d;
    end
  end

  assign bus.clk_phase   = clkPhase_q;
  assign bus.sam_phase   = samPhase_q;
  assign bus.sym_count   = symCount_q;
  assign bus.sam_clk_ena = samEna;
  assign bus.sym_clk_ena = symEna;
  assign bus.frame_ena   = frameEna;
endmodule

// File: tb/tb_clk_ena_gen.sv
// tb_clk_ena_gen
// Bench for clk_ena_gen with three instances: defaults (4/4/64), an odd
// configuration (3/5/7) and the degenerate 1/1/1 case. All share sys_clk,
// reset, run and sync. The reference model keeps, per instance, the number
// of run cycles since the last reset/sync (modulo the frame period) and
// derives every phase and enable from it with division and remainder.
module tb_clk_ena_gen;
  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic run     = 1'b0;
  logic sync    = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  int nA = 0;
  int nB = 0;
  int nC = 0;

  clk_ena_gen_if #(.SAM_DIV(4), .SPS(4), .FRAME_LEN(64)) ifA ();
  clk_ena_gen_if #(.SAM_DIV(3), .SPS(5), .FRAME_LEN(7))  ifB ();
  clk_ena_gen_if #(.SAM_DIV(1), .SPS(1), .FRAME_LEN(1))  ifC ();

  assign ifA.run = run;
  assign ifA.sync = sync;
  assign ifB.run = run;
  assign ifB.sync = sync;
  assign ifC.run = run;
  assign ifC.sync = sync;

  clk_ena_gen #(.SAM_DIV(4), .SPS(4), .FRAME_LEN(64)) dutA (
    .sys_clk(sys_clk), .reset(reset), .bus(ifA.slave));
  clk_ena_gen #(.SAM_DIV(3), .SPS(5), .FRAME_LEN(7)) dutB (
    .sys_clk(sys_clk), .reset(reset), .bus(ifB.slave));
  clk_ena_gen #(.SAM_DIV(1), .SPS(1), .FRAME_LEN(1)) dutC (
    .sys_clk(sys_clk), .reset(reset), .bus(ifC.slave));

  always #5 sys_clk = ~sys_clk;

  // Reference model: elapsed run cycles since alignment, per configuration.
  always @(posedge sys_clk) begin
    if (reset || sync) begin
      nA <= 0;
      nB <= 0;
      nC <= 0;
    end else if (run) begin
      nA <= (nA + 1) % (4 * 4 * 64);
      nB <= (nB + 1) % (3 * 5 * 7);
      nC <= 0;
    end
  end

  typedef struct {
    bit rst;
    bit rn;
    bit sy;
    int clk;
    int sam;
    int sym;
    bit se;
    bit ye;
    bit fe;
  } vec_t;

  vec_t tbl[19];

  task automatic checkVal(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs and moves to the falling edge for sampling.
  task automatic applyStimulus(input bit r, input bit rn, input bit s);
    reset = r;
    run   = rn;
    sync  = s;
    @(negedge sys_clk);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkDut(input string tag, input int n, input int sd,
                          input int sps, input int fl, input int clkP,
                          input int samP, input int symC, input int se,
                          input int ye, input int fe);
    int  symLen;
    int  frmLen;
    bit  active;
    symLen = sd * sps;
    frmLen = symLen * fl;
    active = run && !sync && !reset;
    checkVal({tag, ".clk_phase"},   clkP, n % sd);
    checkVal({tag, ".sam_phase"},   samP, (n / sd) % sps);
    checkVal({tag, ".sym_count"},   symC, (n / symLen) % fl);
    checkVal({tag, ".sam_clk_ena"}, se, int'(active && ((n + 1) % sd == 0)));
    checkVal({tag, ".sym_clk_ena"}, ye, int'(active && ((n + 1) % symLen == 0)));
    checkVal({tag, ".frame_ena"},   fe, int'(active && ((n + 1) % frmLen == 0)));
  endtask

  task automatic checkOutput();
    checkDut("A", nA, 4, 4, 64, int'(ifA.clk_phase), int'(ifA.sam_phase),
             int'(ifA.sym_count), int'(ifA.sam_clk_ena),
             int'(ifA.sym_clk_ena), int'(ifA.frame_ena));
    checkDut("B", nB, 3, 5, 7, int'(ifB.clk_phase), int'(ifB.sam_phase),
             int'(ifB.sym_count), int'(ifB.sam_clk_ena),
             int'(ifB.sym_clk_ena), int'(ifB.frame_ena));
    checkDut("C", nC, 1, 1, 1, int'(ifC.clk_phase), int'(ifC.sam_phase),
             int'(ifC.sym_count), int'(ifC.sam_clk_ena),
             int'(ifC.sym_clk_ena), int'(ifC.frame_ena));
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput();
    tick();
  endtask

  task automatic runCycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput();
      tick();
    end
  endtask

  initial begin
    int firstSamA, firstSymA, firstFrameA, samCntA, symCntA;
    int firstFrameB, frameCntB, maxClkB, maxSamB, maxSymB, cntC;

    // Hand-derived vectors for the default instance: reset, hold, sync.
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 2, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 3, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 3, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 3, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 2, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 3, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[17] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};

    $display("[TB] start");
    tick();
    tick();

    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].rn, tbl[i].sy);
      checkVal($sformatf("tbl%0d.clk_phase", i),   int'(ifA.clk_phase),   tbl[i].clk);
      checkVal($sformatf("tbl%0d.sam_phase", i),   int'(ifA.sam_phase),   tbl[i].sam);
      checkVal($sformatf("tbl%0d.sym_count", i),   int'(ifA.sym_count),   tbl[i].sym);
      checkVal($sformatf("tbl%0d.sam_clk_ena", i), int'(ifA.sam_clk_ena), int'(tbl[i].se));
      checkVal($sformatf("tbl%0d.sym_clk_ena", i), int'(ifA.sym_clk_ena), int'(tbl[i].ye));
      checkVal($sformatf("tbl%0d.frame_ena", i),   int'(ifA.frame_ena),   int'(tbl[i].fe));
      checkOutput();
      tick();
    end

    // Continuous run over one full default frame: enable timing and ranges.
    resetCycle();
    firstSamA = -1; firstSymA = -1; firstFrameA = -1; firstFrameB = -1;
    samCntA = 0; symCntA = 0; frameCntB = 0; cntC = 0;
    maxClkB = 0; maxSamB = 0; maxSymB = 0;
    for (int c = 0; c < 1024; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput();
      if (ifA.sam_clk_ena) begin
        samCntA++;
        if (firstSamA < 0) firstSamA = c;
      end
      if (ifA.sym_clk_ena) begin
        symCntA++;
        if (firstSymA < 0) firstSymA = c;
      end
      if (ifA.frame_ena && firstFrameA < 0) firstFrameA = c;
      if (ifB.frame_ena) begin
        frameCntB++;
        if (firstFrameB < 0) firstFrameB = c;
      end
      if (ifC.sam_clk_ena && ifC.sym_clk_ena && ifC.frame_ena) cntC++;
      if (int'(ifB.clk_phase) > maxClkB) maxClkB = int'(ifB.clk_phase);
      if (int'(ifB.sam_phase) > maxSamB) maxSamB = int'(ifB.sam_phase);
      if (int'(ifB.sym_count) > maxSymB) maxSymB = int'(ifB.sym_count);
      tick();
    end
    checkVal("A.firstSam",   firstSamA,   3);
    checkVal("A.firstSym",   firstSymA,   15);
    checkVal("A.firstFrame", firstFrameA, 1023);
    checkVal("A.samCount",   samCntA,     256);
    checkVal("A.symCount",   symCntA,     64);
    checkVal("B.firstFrame", firstFrameB, 104);
    checkVal("B.frameCount", frameCntB,   9);
    checkVal("B.maxClk",     maxClkB,     2);
    checkVal("B.maxSam",     maxSamB,     4);
    checkVal("B.maxSym",     maxSymB,     6);
    checkVal("C.allEna",     cntC,        1024);

    // Pause with run low while clk_phase sits at 2.
    runCycles(2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkVal("hold.clk_phase", int'(ifA.clk_phase), 2);
      checkVal("hold.sam_ena", int'(ifA.sam_clk_ena), 0);
      checkOutput();
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkVal("resume0.sam_ena", int'(ifA.sam_clk_ena), 0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkVal("resume1.sam_ena", int'(ifA.sam_clk_ena), 1);
    tick();

    // Sync at clk_phase=3, sam_phase=3, sym_count=10.
    resetCycle();
    runCycles(175);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkVal("syncAt.clk_phase", int'(ifA.clk_phase), 3);
    checkVal("syncAt.sam_phase", int'(ifA.sam_phase), 3);
    checkVal("syncAt.sym_count", int'(ifA.sym_count), 10);
    checkVal("syncAt.enables",
             int'({ifA.sam_clk_ena, ifA.sym_clk_ena, ifA.frame_ena}), 0);
    checkOutput();
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (k == 0) begin
        checkVal("postSync.counters",
                 int'(ifA.clk_phase) + int'(ifA.sam_phase) + int'(ifA.sym_count), 0);
      end
      checkVal($sformatf("postSync%0d.sam_ena", k), int'(ifA.sam_clk_ena), int'(k == 3));
      checkOutput();
      tick();
    end

    // Reset mid-frame at sym_count=20, then reset held with sync and run.
    resetCycle();
    runCycles(325);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkVal("rstAt.sym_count", int'(ifA.sym_count), 20);
    checkVal("rstAt.enables",
             int'({ifA.sam_clk_ena, ifA.sym_clk_ena, ifA.frame_ena}), 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkVal($sformatf("rstHeld%0d.counters", k),
               int'(ifA.clk_phase) + int'(ifA.sam_phase) + int'(ifA.sym_count), 0);
      checkOutput();
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkVal($sformatf("postRst%0d.sam_ena", k), int'(ifA.sam_clk_ena), int'(k == 3));
      checkOutput();
      tick();
    end

    // Randomized run/sync/reset against the model for all three instances.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
                    $urandom_range(0, 99) < 4);
      checkOutput();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
